// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a synchronous score ROM and drives note/start/stop for the synthesizer voice.
// Durations are counted in ticks of TICK_DIV clock cycles; an optional silent gap follows each sounded note.
module melody_sequencer #(
  parameter int TICK_DIV  = 12000,
  parameter int GAP_TICKS = 10,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              halt,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        note,
  output logic              start,
  output logic              stop,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int CNT_W = 16;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_TICKS);

  state_t            state, state_nx;
  logic [PRE_W-1:0]  pre, pre_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              rest, rest_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [6:0]        note_nx;
  logic              start_nx, stop_nx, done_nx, busy_nx;
  logic [6:0]        dur_s;
  logic              tick_s, last_s;

  // Next-state and next-output decode; halt from any active state overrides the normal flow.
  always_comb begin
    dur_s    = (rom_data[6:0] == 7'd0) ? 7'd1 : rom_data[6:0];
    tick_s   = (pre == PRE_LAST);
    last_s   = tick_s && (cnt == 16'd1);
    state_nx = state;
    pre_nx   = pre;
    cnt_nx   = cnt;
    rest_nx  = rest;
    addr_nx  = rom_addr;
    note_nx  = note;
    start_nx = 1'b0;
    stop_nx  = 1'b0;
    done_nx  = 1'b0;

    if (halt && (state != IDLE)) begin
      stop_nx  = 1'b1;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play && !halt) begin
            addr_nx  = {ADDR_W{1'b0}};
            state_nx = FETCH;
          end else begin
            state_nx = IDLE;
          end
        end
        FETCH: state_nx = LOAD;
        LOAD: begin
          if (rom_data[15]) begin
            // An end marker at address 0 would loop forever without sounding anything, so it finishes.
            if (loop && (rom_addr != {ADDR_W{1'b0}})) begin
              addr_nx  = {ADDR_W{1'b0}};
              state_nx = FETCH;
            end else begin
              stop_nx  = 1'b1;
              done_nx  = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            cnt_nx   = CNT_W'(dur_s);
            pre_nx   = {PRE_W{1'b0}};
            rest_nx  = rom_data[14];
            state_nx = HOLD;
            if (rom_data[14]) begin
              stop_nx = 1'b1;
            end else begin
              note_nx  = rom_data[13:7];
              start_nx = 1'b1;
            end
          end
        end
        HOLD, GAP: begin
          if (tick_s) begin
            pre_nx = {PRE_W{1'b0}};
            cnt_nx = cnt - 16'd1;
          end else begin
            pre_nx = pre + PRE_W'(1);
          end
          if (last_s) begin
            if ((state == HOLD) && !rest && (GAP_LOAD != 16'd0)) begin
              stop_nx  = 1'b1;
              cnt_nx   = GAP_LOAD;
              pre_nx   = {PRE_W{1'b0}};
              state_nx = GAP;
            end else begin
              addr_nx  = rom_addr + ADDR_W'(1);
              state_nx = FETCH;
            end
          end else begin
            state_nx = state;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    busy_nx = (state_nx != IDLE);
  end

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pre      <= {PRE_W{1'b0}};
      cnt      <= 16'd0;
      rest     <= 1'b0;
      rom_addr <= {ADDR_W{1'b0}};
      note     <= 7'd0;
      start    <= 1'b0;
      stop     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      pre      <= pre_nx;
      cnt      <= cnt_nx;
      rest     <= rest_nx;
      rom_addr <= addr_nx;
      note     <= note_nx;
      start    <= start_nx;
      stop     <= stop_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scores plus random scores, compared cycle by cycle
// against an event-timeline model built from the score with plain arithmetic.
module tb_melody_sequencer;
  localparam int T   = 4;
  localparam int G   = 1;
  localparam int WIN = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        play = 1'b0;
  logic        halt = 1'b0;
  logic        loop_in = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic [6:0]  note;
  logic        start, stop, busy, done;
  logic [15:0] rom [0:255];

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] m_note;
  logic [7:0] m_addr;
  bit         e_busy [WIN];
  bit         e_start[WIN];
  bit         e_stop [WIN];
  bit         e_done [WIN];
  logic [6:0] e_note [WIN];
  logic [7:0] e_addr [WIN];
  logic       o_busy [WIN];
  logic       o_start[WIN];
  logic       o_stop [WIN];
  logic       o_done [WIN];
  logic [6:0] o_note [WIN];
  logic [7:0] o_addr [WIN];

  melody_sequencer #(.TICK_DIV(T), .GAP_TICKS(G), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .halt(halt), .loop(loop_in),
    .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .start(start), .stop(stop), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mark_busy(input int a, input int b);
    for (int k = a; k < b && k < WIN; k++) e_busy[k] = 1'b1;
  endfunction

  function automatic void fill_note(input int from, input logic [6:0] v);
    for (int k = from; k < WIN; k++) e_note[k] = v;
  endfunction

  function automatic void fill_addr(input int from, input logic [7:0] v);
    for (int k = from; k < WIN; k++) e_addr[k] = v;
  endfunction

  // Timeline model: index k is the cycle after edge k, edge 0 being the play edge.
  function automatic void build_model(input bit lp, input int hc);
    int t, e, h, nx, a, d;
    bit fin;
    logic [15:0] ent;
    for (int k = 0; k < WIN; k++) begin
      e_busy[k] = 1'b0; e_start[k] = 1'b0; e_stop[k] = 1'b0; e_done[k] = 1'b0;
      e_note[k] = m_note; e_addr[k] = m_addr;
    end
    fill_addr(0, 8'd0);
    t = 0; a = 0; fin = 1'b0;
    while (!fin && t < WIN) begin
      e = t + 2;
      mark_busy(t, e);
      ent = rom[a];
      if (ent[15]) begin
        if (lp && a != 0) begin
          a = 0;
          fill_addr(e, 8'd0);
          t = e;
        end else begin
          if (e < WIN) begin e_stop[e] = 1'b1; e_done[e] = 1'b1; end
          fin = 1'b1;
        end
      end else begin
        d = (ent[6:0] == 7'd0) ? 1 : int'(ent[6:0]);
        if (ent[14]) begin
          if (e < WIN) e_stop[e] = 1'b1;
        end else begin
          if (e < WIN) e_start[e] = 1'b1;
          fill_note(e, ent[13:7]);
        end
        h = e + d * T;
        mark_busy(e, h);
        if (!ent[14] && G > 0) begin
          if (h < WIN) e_stop[h] = 1'b1;
          nx = h + G * T;
          mark_busy(h, nx);
        end else begin
          nx = h;
        end
        a = (a + 1) % 256;
        fill_addr(nx, 8'(a));
        t = nx;
      end
    end
    if (hc >= 1 && hc < WIN && e_busy[hc-1]) begin
      for (int k = hc; k < WIN; k++) begin
        e_start[k] = 1'b0; e_done[k] = 1'b0; e_busy[k] = 1'b0;
        e_stop[k]  = (k == hc);
        e_note[k]  = e_note[hc-1];
        e_addr[k]  = e_addr[hc-1];
      end
    end
    m_note = e_note[WIN-1];
    m_addr = e_addr[WIN-1];
  endfunction

  // Plays the ROM score once: play at edge 0, optional halt at edge hc, optional extra play at edge pj.
  task automatic run(input bit lp, input int hc, input int pj, input string name);
    int pj_eff;
    build_model(lp, hc);
    pj_eff = (pj >= 1 && pj < WIN && (e_busy[pj-1] || pj == hc)) ? pj : 0;
    loop_in = lp;
    @(negedge clk);
    play = 1'b1; halt = 1'b0;
    for (int k = 0; k < WIN; k++) begin
      @(negedge clk);
      o_busy[k] = busy; o_start[k] = start; o_stop[k] = stop;
      o_done[k] = done; o_note[k] = note; o_addr[k] = rom_addr;
      play = (k + 1 == pj_eff);
      halt = (k + 1 == hc);
      check_eq($sformatf("%s cyc%0d {busy,start,stop,done,note,addr}", name, k),
               {busy, start, stop, done, note, rom_addr},
               {e_busy[k], e_start[k], e_stop[k], e_done[k], e_note[k], e_addr[k]});
    end
    play = 1'b0; halt = 1'b0;
  endtask

  task automatic check_s1(input string p);
    check_eq({p, " start@2"}, 32'(o_start[2]), 32'd1);
    check_eq({p, " note@2"},  32'(o_note[2]),  32'h15);
    check_eq({p, " stop@13"}, 32'(o_stop[13]), 32'd0);
    check_eq({p, " stop@14"}, 32'(o_stop[14]), 32'd1);
    check_eq({p, " addr@17"}, 32'(o_addr[17]), 32'd0);
    check_eq({p, " addr@18"}, 32'(o_addr[18]), 32'd1);
    check_eq({p, " busy@19"}, 32'(o_busy[19]), 32'd1);
    check_eq({p, " done@20"}, 32'(o_done[20]), 32'd1);
    check_eq({p, " stop@20"}, 32'(o_stop[20]), 32'd1);
    check_eq({p, " busy@20"}, 32'(o_busy[20]), 32'd0);
  endtask

  task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    rom[0] = a; rom[1] = b; rom[2] = c;
  endtask

  function automatic int count_done();
    int c = 0;
    for (int k = 0; k < WIN; k++) c += int'(o_done[k]);
    return c;
  endfunction

  initial begin
    int len;
    bit lp;
    int hc, pj;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    m_note = 7'd0; m_addr = 8'd0;

    repeat (2) @(negedge clk);
    check_eq("reset outputs", {busy, start, stop, done, note, rom_addr}, 32'd0);
    rst_n = 1'b1;

    // note 7'h15 dur 3, then end
    load3(16'h0A83, 16'h8000, 16'h0000);
    run(1'b0, 0, 5, "s1");
    check_s1("s1");

    // rest dur 2, note 7'h2A dur 0, end
    load3(16'h4002, 16'h1500, 16'h8000);
    run(1'b0, 0, 0, "s2");
    check_eq("s2 stop@2",   32'(o_stop[2]),   32'd1);
    check_eq("s2 start@2",  32'(o_start[2]),  32'd0);
    check_eq("s2 start@12", 32'(o_start[12]), 32'd1);
    check_eq("s2 note@12",  32'(o_note[12]),  32'h2A);
    check_eq("s2 stop@15",  32'(o_stop[15]),  32'd0);
    check_eq("s2 stop@16",  32'(o_stop[16]),  32'd1);

    // Looping one-note score: start-to-start is hold + gap + 2 (marker) + 2 (entry 0).
    load3(16'h0A81, 16'h8000, 16'h0000);
    run(1'b1, 28, 20, "loop");
    check_eq("loop start@14", 32'(o_start[14]), 32'd1);
    check_eq("loop start@26", 32'(o_start[26]), 32'd1);
    check_eq("loop halt stop@28", 32'(o_stop[28]), 32'd1);
    check_eq("loop halt busy@28", 32'(o_busy[28]), 32'd0);
    check_eq("loop no done", 32'(count_done()), 32'd0);

    // Halt during the second note's HOLD keeps rom_addr at 1.
    load3(16'h4002, 16'h1500, 16'h8000);
    run(1'b0, 14, 0, "halt");
    check_eq("halt stop@14", 32'(o_stop[14]), 32'd1);
    check_eq("halt busy@14", 32'(o_busy[14]), 32'd0);
    check_eq("halt addr@20", 32'(o_addr[20]), 32'd1);
    check_eq("halt no done", 32'(count_done()), 32'd0);

    load3(16'h0A83, 16'h8000, 16'h0000);
    run(1'b0, 0, 0, "replay");
    check_eq("replay addr@0", 32'(o_addr[0]), 32'd0);
    check_s1("replay");

    load3(16'h8000, 16'h0A83, 16'h8000);
    run(1'b1, 0, 0, "end0");
    check_eq("end0 done@2", 32'(o_done[2]), 32'd1);
    check_eq("end0 busy@3", 32'(o_busy[3]), 32'd0);

    @(negedge clk);
    play = 1'b1; halt = 1'b1;
    @(negedge clk);
    play = 1'b0; halt = 1'b0;
    check_eq("halt+play idle {busy,start,stop}", {busy, start, stop}, 32'd0);
    @(negedge clk);
    check_eq("halt+play idle busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of the gap.
    load3(16'h0A83, 16'h8000, 16'h0000);
    loop_in = 1'b0;
    @(negedge clk); play = 1'b1;
    @(negedge clk); play = 1'b0;
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("rst mid-gap outputs", {busy, start, stop, done, note, rom_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_note = 7'd0; m_addr = 8'd0;
    run(1'b0, 0, 0, "postrst");
    check_s1("postrst");

    for (int s = 0; s < 25; s++) begin
      len = $urandom_range(0, 5);
      for (int i = 0; i < len; i++) begin
        rom[i] = {1'b0, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  7'($urandom_range(0, 127)), 7'($urandom_range(0, 5))};
      end
      rom[len] = 16'h8000 | 16'($urandom_range(0, 32767));
      lp = ($urandom_range(0, 1) == 1);
      if (lp) hc = $urandom_range(3, 300);
      else    hc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 250) : 0;
      pj = $urandom_range(1, 200);
      run(lp, hc, pj, $sformatf("rnd%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
